// File: rtl/axis_data_to_axis_hex_string.sv
// Converts each AXI-Stream input beat into a framed ASCII hex string on an
// 8-bit AXI-Stream output: #<data>[;*<user>][;&<dest>]<term>.
module axis_data_to_axis_hex_string #(
   parameter int unsigned SBUS_WIDTH   = 4,
   parameter int unsigned USER_WIDTH   = 4,
   parameter int unsigned DEST_WIDTH   = 4,
   parameter bit          USER_EN      = 1'b1,
   parameter bit          DEST_EN      = 1'b1,
   parameter bit          TERM_ON_LAST = 1'b0,
   parameter bit          LOWER_CASE   = 1'b0,
   parameter logic [7:0]  DELIMITER    = 8'h3B,
   parameter logic [7:0]  TERMINATION  = 8'h0A,
   parameter logic [7:0]  DATA_PREFIX  = 8'h23,
   parameter logic [7:0]  USER_PREFIX  = 8'h2A,
   parameter logic [7:0]  DEST_PREFIX  = 8'h26
) (
   input  logic                    aclk,
   input  logic                    arstn,
   input  logic [SBUS_WIDTH*8-1:0] s_axis_tdata,
   input  logic [SBUS_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tlast,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready
);

   localparam int unsigned DATA_W = SBUS_WIDTH * 8;
   localparam int unsigned NIB_W  = (SBUS_WIDTH > 1) ? $clog2(2 * SBUS_WIDTH) : 1;
   localparam int unsigned UDIG   = (USER_WIDTH + 3) / 4;
   localparam int unsigned DDIG   = (DEST_WIDTH + 3) / 4;
   localparam int unsigned MAXDIG = (UDIG > DDIG) ? UDIG : DDIG;
   localparam int unsigned CNT_W  = (MAXDIG > 1) ? $clog2(MAXDIG) : 1;
   // Sideband fields are zero-padded to a power-of-two nibble count so the
   // digit counter indexes them without range gaps.
   localparam int unsigned PAD_W  = 4 * (1 << CNT_W);

   typedef enum logic [3:0] {
      ST_IDLE, ST_PRE, ST_DATA, ST_UDLM, ST_UPRE, ST_UHEX,
      ST_DDLM, ST_DPRE, ST_DHEX, ST_END
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [SBUS_WIDTH-1:0] keep_q, keep_d;
   logic                  last_q, last_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic [NIB_W-1:0]      nib_q, nib_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            m_tdata_q, m_tdata_d;
   logic                  m_tvalid_q, m_tvalid_d;
   logic                  s_tready_q, s_tready_d;

   logic                  accept;
   logic                  found;
   int unsigned           fidx;
   int unsigned           lim;
   state_t                after_data;
   state_t                after_user;
   logic [PAD_W-1:0]      user_pad;
   logic [PAD_W-1:0]      dest_pad;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return (LOWER_CASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
   endfunction

   // Next state, capture and next output character
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      keep_d    = keep_q;
      last_d    = last_q;
      user_d    = user_q;
      dest_d    = dest_q;
      nib_d     = nib_q;
      cnt_d     = cnt_q;
      m_tdata_d = 8'h00;
      accept    = m_tvalid_q & m_axis_tready;

      after_user = DEST_EN ? ST_DDLM : ST_END;
      after_data = USER_EN ? ST_UDLM : after_user;

      // Highest kept byte strictly below the current one (or overall from PRE)
      lim   = (state_q == ST_PRE) ? SBUS_WIDTH : (32'(nib_q) >> 1);
      found = 1'b0;
      fidx  = 0;
      for (int unsigned i = 0; i < SBUS_WIDTH; i++) begin
         if (keep_q[i] && (i < lim)) begin
            found = 1'b1;
            fidx  = i;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (s_tready_q && s_axis_tvalid) begin
               data_d  = s_axis_tdata;
               keep_d  = s_axis_tkeep;
               last_d  = s_axis_tlast;
               user_d  = s_axis_tuser;
               dest_d  = s_axis_tdest;
               state_d = ST_PRE;
            end
         end
         ST_PRE, ST_DATA: begin
            if (accept) begin
               if ((state_q == ST_DATA) && nib_q[0]) begin
                  nib_d = nib_q - NIB_W'(1);
               end else if (found) begin
                  state_d = ST_DATA;
                  nib_d   = NIB_W'(2 * fidx + 1);
               end else begin
                  state_d = after_data;
               end
            end
         end
         ST_UDLM: if (accept) state_d = ST_UPRE;
         ST_UPRE: begin
            if (accept) begin
               state_d = ST_UHEX;
               cnt_d   = CNT_W'(UDIG - 1);
            end
         end
         ST_UHEX: begin
            if (accept) begin
               if (cnt_q == '0) state_d = after_user;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         ST_DDLM: if (accept) state_d = ST_DPRE;
         ST_DPRE: begin
            if (accept) begin
               state_d = ST_DHEX;
               cnt_d   = CNT_W'(DDIG - 1);
            end
         end
         ST_DHEX: begin
            if (accept) begin
               if (cnt_q == '0) state_d = ST_END;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         ST_END:  if (accept) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      s_tready_d = (state_d == ST_IDLE);
      m_tvalid_d = (state_d != ST_IDLE);
      user_pad   = PAD_W'(user_d);
      dest_pad   = PAD_W'(dest_d);

      // Hold the presented character until it is accepted
      if (m_tvalid_q && !m_axis_tready) begin
         m_tdata_d = m_tdata_q;
      end else begin
         case (state_d)
            ST_PRE:           m_tdata_d = DATA_PREFIX;
            ST_DATA:          m_tdata_d = hex_char(data_d[{nib_d, 2'b00} +: 4]);
            ST_UDLM, ST_DDLM: m_tdata_d = DELIMITER;
            ST_UPRE:          m_tdata_d = USER_PREFIX;
            ST_UHEX:          m_tdata_d = hex_char(user_pad[{cnt_d, 2'b00} +: 4]);
            ST_DPRE:          m_tdata_d = DEST_PREFIX;
            ST_DHEX:          m_tdata_d = hex_char(dest_pad[{cnt_d, 2'b00} +: 4]);
            ST_END:           m_tdata_d = (TERM_ON_LAST && !last_d) ? DELIMITER : TERMINATION;
            default:          m_tdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         keep_q     <= '0;
         last_q     <= 1'b0;
         user_q     <= '0;
         dest_q     <= '0;
         nib_q      <= '0;
         cnt_q      <= '0;
         m_tdata_q  <= 8'h00;
         m_tvalid_q <= 1'b0;
         s_tready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         keep_q     <= keep_d;
         last_q     <= last_d;
         user_q     <= user_d;
         dest_q     <= dest_d;
         nib_q      <= nib_d;
         cnt_q      <= cnt_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         s_tready_q <= s_tready_d;
      end
   end

   assign s_axis_tready = s_tready_q;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tvalid = m_tvalid_q;

endmodule

// File: doc/axis_data_to_axis_hex_string.md
Name: axis_data_to_axis_hex_string

Overview:
- Converts each AXI-Stream input beat into a framed, human-readable ASCII hex string on an 8-bit AXI-Stream output.
- Input beat: SBUS_WIDTH data bytes with byte-qualifying tkeep, tlast, tuser and tdest.
- Next generation of the data-to-string converter:
  - parametrised bus, user and dest widths;
  - tkeep-aware byte suppression;
  - per-field enables;
  - packet-mode termination on tlast;
  - selectable hex letter case.
- Sits between binary AXIS producers and UART/console sinks.

Parameters:
SBUS_WIDTH, 4, input data width in bytes (1..16)
USER_WIDTH, 4, tuser width in bits (1..32)
DEST_WIDTH, 4, tdest width in bits (1..32)
USER_EN, 1, 1 = emit user field
DEST_EN, 1, 1 = emit dest field
TERM_ON_LAST, 0, 0 = TERMINATION after every beat; 1 = DELIMITER between beats, TERMINATION only after tlast beat
LOWER_CASE, 0, 1 = hex letters a-f, 0 = A-F
DELIMITER, ";", 8-bit field/beat separator
TERMINATION, "\n", 8-bit string terminator
DATA_PREFIX, "#", 8-bit data field prefix
USER_PREFIX, "*", 8-bit user field prefix
DEST_PREFIX, "&", 8-bit dest field prefix

Ports:
aclk  in  1  stream clock
arstn  in  1  asynchronous active-low reset
s_axis_tdata  in  SBUS_WIDTH*8  input data
s_axis_tkeep  in  SBUS_WIDTH  byte qualifiers
s_axis_tlast  in  1  packet end
s_axis_tuser  in  USER_WIDTH  user sideband
s_axis_tdest  in  DEST_WIDTH  dest sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  8  ASCII character
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready

Behaviour:
- One clock (aclk); reset asynchronous, active-low (arstn).
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=8'h00, FSM=IDLE, all counters 0.
  - Reset mid-string aborts immediately, with no partial termination.
  - First cycle after release: s_axis_tready=1.
- s_axis_tready=1 only in IDLE.
  - On tvalid&tready, register tdata, tkeep, tlast, tuser and tdest; move to PRE.
  - Input is never re-sampled mid-string.
- Output handshake:
  - m_axis_tvalid/m_axis_tdata are registered.
  - Held stable until m_axis_tready=1.
  - FSM advances only on an accepted character (tvalid&tready).
- FSM sequence: IDLE -> PRE -> DATA -> [UDLM -> UPRE -> UHEX] -> [DDLM -> DPRE -> DHEX] -> END -> IDLE. Bracketed groups are skipped when USER_EN=0 / DEST_EN=0.
  - PRE emits DATA_PREFIX.
  - DATA emits two hex digits per kept byte, byte SBUS_WIDTH-1 down to 0, high nibble first. Bytes with tkeep=0 are skipped entirely. If tkeep is all-zero, DATA emits nothing.
  - UDLM/DDLM emit DELIMITER.
  - UPRE/DPRE emit USER_PREFIX/DEST_PREFIX.
  - UHEX emits ceil(USER_WIDTH/4) digits, MS nibble first, zero-extended. DHEX does the same with DEST_WIDTH.
  - END emits TERMINATION, except when TERM_ON_LAST=1 and the captured tlast=0, where it emits DELIMITER.
- Hex encoding: nibble 0-9 -> 8'h30+n; 10-15 -> 8'h41+n-10, or 8'h61+n-10 if LOWER_CASE=1.
- Latency:
  - m_axis_tvalid rises the cycle after input capture.
  - With m_axis_tready held high: one character per cycle.
  - s_axis_tready rises the cycle after the END character is accepted.
  - A beat producing N characters therefore occupies N+1 cycles.
- Counters:
  - Nibble index width is clog2(2*SBUS_WIDTH) minimum 1.
  - The kept-byte search skips zero-keep bytes in the same cycle, so there are no idle cycles between digits.
- m_axis_tvalid=0 in IDLE. No output bubbles inside a string unless the downstream applies backpressure.

Test Plan:
- Defaults (SBUS_WIDTH=4), tdata=32'hDEADBEEF, tkeep=4'hF, tuser=4'h3, tdest=4'hC, tlast=1, m_axis_tready=1:
  - output "#DEADBEEF;*3;&C\n" (16 chars), one per cycle;
  - s_axis_tready=0 throughout, rising the cycle after "\n".
- Same beat, tkeep=4'b0101 -> "#ADEF;*3;&C\n". tkeep=4'h0 -> "#;*3;&C\n".
- TERM_ON_LAST=1, beat1 tdata=32'h00000042 tlast=0, beat2 tdata=32'h000000FF tlast=1, user/dest 0:
  - output "#00000042;*0;&0;#000000FF;*0;&0\n".
- LOWER_CASE=1, USER_EN=0, DEST_EN=0, tdata=32'hABCDEF01 -> "#abcdef01\n".
- USER_WIDTH=5, tuser=5'h1F -> user field "*1F".
- Backpressure and reset:
  - Toggle m_axis_tready pseudo-randomly: identical character sequence; tdata stable while tvalid&!tready.
  - Assert arstn=0 mid-string: m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, the next beat emits a complete fresh string.
